// File: rtl/cdb_arbiter_pkg.sv
`default_nettype none
// ============================================================================
// Module   : cdb_arbiter_pkg
// Brief    : Shared types and defaults for the CDB arbiter slice.
// Revision : 1.0 - initial release
// ============================================================================
package cdb_arbiter_pkg;

    // Default machine configuration: broadcast lanes and FU result ports.
    localparam int NUM_CDB_DEF   = 2;
    localparam int FUNC_UNIT_NUM = 8;

    // Result payload broadcast on every CDB lane.
    typedef struct packed {
        logic [6:0]  dest_prf;
        logic [5:0]  rob_entry;
        logic [31:0] value;
        logic [17:0] branch_address;
        logic        value_valid;
    } CDB_PACKET;

    localparam int CDB_PKT_W = $bits(CDB_PACKET);
    localparam int CDB_SRC_W = $clog2(FUNC_UNIT_NUM);

    // Index of the functional unit that produced a lane's result.
    typedef logic [CDB_SRC_W-1:0] cdb_src_t;

endpackage : cdb_arbiter_pkg
`default_nettype wire

// File: rtl/cdb_arbiter_rr_multi_grant.sv
`default_nettype none
// ============================================================================
// Module   : rr_multi_grant
// Brief    : Combinational rotating-priority selector issuing up to NUM_CDB
//            one-hot grants. Requests are rotated so rr_ptr sits at bit 0,
//            the lowest set bits are peeled off one per lane, and each grant
//            is rotated back into source order.
// Revision : 1.0 - initial release
// ============================================================================
module rr_multi_grant #(
    parameter int NUM_SRC = 8,
    parameter int NUM_CDB = 2,
    parameter int IDX_W   = $clog2(NUM_SRC)
) (
    input  logic [NUM_SRC-1:0]         i_req,
    input  logic [IDX_W-1:0]           i_rr_ptr,
    output logic [NUM_CDB*NUM_SRC-1:0] o_grant,
    output logic                       o_any,
    output logic [IDX_W-1:0]           o_last_idx
);

    logic [2*NUM_SRC-1:0] w_req_dbl;
    logic [NUM_SRC-1:0]   w_rot;
    logic [NUM_SRC-1:0]   w_rem;
    logic [NUM_SRC-1:0]   w_rot_grant [NUM_CDB];
    logic [2*NUM_SRC-1:0] w_ungr_dbl  [NUM_CDB];
    logic [IDX_W-1:0]     w_last_pos;
    logic [IDX_W:0]       w_sum;

    // Rotate requests right so the highest-priority source lands on bit 0.
    assign w_req_dbl = {i_req, i_req} >> i_rr_ptr;
    assign w_rot     = w_req_dbl[NUM_SRC-1:0];

    // Peel off the lowest remaining request for each lane in turn; later
    // lanes are further along the scan, so the last hit is the last grant.
    always_comb begin
        w_rem      = w_rot;
        w_last_pos = '0;
        for (int k = 0; k < NUM_CDB; k++) begin
            w_rot_grant[k] = w_rem & (~w_rem + NUM_SRC'(1));
            w_rem          = w_rem & ~w_rot_grant[k];
            for (int j = 0; j < NUM_SRC; j++) begin
                if (w_rot_grant[k][j]) begin
                    w_last_pos = IDX_W'(j);
                end
            end
        end
    end

    // Rotate each lane's grant back into source numbering.
    generate
        for (genvar k = 0; k < NUM_CDB; k++) begin : g_lane
            assign w_ungr_dbl[k] = {w_rot_grant[k], w_rot_grant[k]} << i_rr_ptr;
            assign o_grant[k*NUM_SRC +: NUM_SRC] = w_ungr_dbl[k][2*NUM_SRC-1:NUM_SRC];
        end
    endgenerate

    assign o_any = |w_rot_grant[0];

    // Map the last rotated position back to a source index, modulo NUM_SRC.
    assign w_sum      = {1'b0, i_rr_ptr} + {1'b0, w_last_pos};
    assign o_last_idx = (w_sum >= (IDX_W+1)'(NUM_SRC)) ? IDX_W'(w_sum - (IDX_W+1)'(NUM_SRC))
                                                        : w_sum[IDX_W-1:0];

endmodule : rr_multi_grant
`default_nettype wire

// File: rtl/cdb_arbiter.sv
`default_nettype none
// ============================================================================
// Module   : cdb_arbiter
// Brief    : Buffered arbiter from FU result ports onto NUM_CDB registered
//            broadcast lanes. Each source owns one holding entry; occupied
//            entries compete under rotating priority so no unit starves.
// Revision : 1.0 - initial release
// ============================================================================
module cdb_arbiter
    import cdb_arbiter_pkg::*;
#(
    parameter int NUM_SRC = FUNC_UNIT_NUM,
    parameter int NUM_CDB = NUM_CDB_DEF,
    parameter int PKT_W   = CDB_PKT_W,
    parameter int BYPASS  = 0,
    parameter int CNT_W   = 16
) (
    input  logic                               i_clock,
    input  logic                               i_reset,
    input  logic                               i_nuke,
    input  logic [NUM_SRC-1:0]                 i_fu_valid,
    input  logic [NUM_SRC*PKT_W-1:0]           i_fu_packet,
    output logic [NUM_SRC-1:0]                 o_src_ready,
    output logic [NUM_CDB-1:0]                 o_cdb_valid,
    output logic [NUM_CDB*PKT_W-1:0]           o_cdb_packet,
    output logic [NUM_CDB*$clog2(NUM_SRC)-1:0] o_cdb_src,
    output logic [CNT_W-1:0]                   o_contention_cnt
);

    localparam int   IDX_W       = $clog2(NUM_SRC);
    localparam int   POP_W       = $clog2(NUM_SRC + 1);
    localparam logic c_BYPASS_EN = (BYPASS != 0);

    logic [NUM_SRC-1:0]         r_hv;
    logic [PKT_W-1:0]           r_hp [NUM_SRC];
    logic [IDX_W-1:0]           r_rr;
    logic [NUM_CDB-1:0]         r_cv;
    logic [NUM_CDB*PKT_W-1:0]   r_cp;
    logic [NUM_CDB*IDX_W-1:0]   r_cs;
    logic [CNT_W-1:0]           r_cnt;

    logic                       w_block;
    logic [NUM_SRC-1:0]         w_cand;
    logic [NUM_SRC-1:0]         w_req;
    logic [PKT_W-1:0]           w_cand_pkt [NUM_SRC];
    logic [NUM_CDB*NUM_SRC-1:0] w_grant;
    logic                       w_any;
    logic [IDX_W-1:0]           w_last;
    logic [IDX_W-1:0]           w_next_rr;
    logic [NUM_SRC-1:0]         w_grant_or;
    logic [NUM_SRC-1:0]         w_ready;
    logic [NUM_SRC-1:0]         w_accept;
    logic [NUM_SRC-1:0]         w_bypass_grant;
    logic [NUM_SRC-1:0]         w_load;
    logic [NUM_SRC-1:0]         w_hv_next;
    logic [NUM_CDB-1:0]         w_lane_valid;
    logic [PKT_W-1:0]           w_lane_pkt [NUM_CDB];
    logic [IDX_W-1:0]           w_lane_src [NUM_CDB];
    logic [POP_W-1:0]           w_pop;
    logic                       w_contend;

    // Reset and squash both freeze acceptance and arbitration for the cycle.
    assign w_block = i_reset | i_nuke;

    // An empty slot may present its incoming packet directly when bypass is on.
    assign w_cand = r_hv | ({NUM_SRC{c_BYPASS_EN}} & i_fu_valid & ~r_hv);
    assign w_req  = {NUM_SRC{~w_block}} & w_cand;

    generate
        for (genvar i = 0; i < NUM_SRC; i++) begin : g_cand_pkt
            assign w_cand_pkt[i] = r_hv[i] ? r_hp[i] : i_fu_packet[i*PKT_W +: PKT_W];
        end
    endgenerate

    rr_multi_grant #(
        .NUM_SRC (NUM_SRC),
        .NUM_CDB (NUM_CDB),
        .IDX_W   (IDX_W)
    ) u_grant (
        .i_req      (w_req),
        .i_rr_ptr   (r_rr),
        .o_grant    (w_grant),
        .o_any      (w_any),
        .o_last_idx (w_last)
    );

    assign w_next_rr = (w_last == IDX_W'(NUM_SRC - 1)) ? '0 : w_last + IDX_W'(1);

    // Collapse per-lane grants and steer each winner's payload and index onto its lane.
    always_comb begin
        w_grant_or = '0;
        for (int k = 0; k < NUM_CDB; k++) begin
            w_lane_valid[k] = |w_grant[k*NUM_SRC +: NUM_SRC];
            w_lane_pkt[k]   = '0;
            w_lane_src[k]   = '0;
            for (int i = 0; i < NUM_SRC; i++) begin
                if (w_grant[k*NUM_SRC + i]) begin
                    w_lane_pkt[k] = w_lane_pkt[k] | w_cand_pkt[i];
                    w_lane_src[k] = w_lane_src[k] | IDX_W'(i);
                end
            end
            w_grant_or = w_grant_or | w_grant[k*NUM_SRC +: NUM_SRC];
        end
    end

    // A slot can take a new packet when empty or when draining this cycle.
    assign w_ready        = {NUM_SRC{~w_block}} & (~r_hv | w_grant_or);
    assign w_accept       = i_fu_valid & w_ready;
    assign w_bypass_grant = w_grant_or & ~r_hv;
    assign w_load         = w_accept & ~w_bypass_grant;
    assign w_hv_next      = w_load | (r_hv & ~w_grant_or);

    // Count candidates to detect cycles with more contenders than lanes.
    always_comb begin
        w_pop = '0;
        for (int i = 0; i < NUM_SRC; i++) begin
            w_pop = w_pop + POP_W'(w_cand[i]);
        end
    end
    assign w_contend = (w_pop > POP_W'(NUM_CDB));

    // Control state, lane registers and the contention counter.
    always_ff @(posedge i_clock) begin
        if (i_reset) begin
            r_hv  <= '0;
            r_rr  <= '0;
            r_cv  <= '0;
            r_cp  <= '0;
            r_cs  <= '0;
            r_cnt <= '0;
        end else begin
            if (w_contend && (r_cnt != {CNT_W{1'b1}})) begin
                r_cnt <= r_cnt + CNT_W'(1);
            end
            if (i_nuke) begin
                r_hv <= '0;
                r_cv <= '0;
                r_rr <= '0;
            end else begin
                r_hv <= w_hv_next;
                r_cv <= w_lane_valid;
                for (int k = 0; k < NUM_CDB; k++) begin
                    if (w_lane_valid[k]) begin
                        r_cp[k*PKT_W +: PKT_W] <= w_lane_pkt[k];
                        r_cs[k*IDX_W +: IDX_W] <= w_lane_src[k];
                    end
                end
                if (w_any) begin
                    r_rr <= w_next_rr;
                end
            end
        end
    end

    // Holding payloads need no reset; their valid bits gate every use.
    always_ff @(posedge i_clock) begin
        for (int i = 0; i < NUM_SRC; i++) begin
            if (w_load[i]) begin
                r_hp[i] <= i_fu_packet[i*PKT_W +: PKT_W];
            end
        end
    end

    assign o_src_ready      = w_ready;
    assign o_cdb_valid      = r_cv;
    assign o_cdb_packet     = r_cp;
    assign o_cdb_src        = r_cs;
    assign o_contention_cnt = r_cnt;

endmodule : cdb_arbiter
`default_nettype wire

// File: tb/tb_cdb_arbiter.sv
`default_nettype none
// ============================================================================
// Module   : tb_cdb_arbiter
// Brief    : Self-checking bench for cdb_arbiter (8 sources, 2 lanes), with
//            one non-bypass and one bypass instance sharing the stimulus.
// Revision : 1.0 - initial release
// ============================================================================
module tb_cdb_arbiter;

    localparam int NS = 8;
    localparam int NC = 2;
    localparam int PW = 64;
    localparam int CW = 16;

    logic            clk = 1'b0;
    logic            rst;
    logic            nuke;
    logic [NS-1:0]   fu_valid;
    logic [NS*PW-1:0] fu_pkt;

    logic [NS-1:0]   ready0, ready1;
    logic [NC-1:0]   cv0, cv1;
    logic [NC*PW-1:0] cp0, cp1;
    logic [NC*3-1:0] cs0, cs1;
    logic [CW-1:0]   cnt0, cnt1;

    int n_cmp  = 0;
    int n_fail = 0;

    // Reference model state, one copy per instance (index = bypass enable).
    bit          m_hv  [2][NS];
    logic [63:0] m_hp  [2][NS];
    int          m_rr  [2];
    bit          m_cv  [2][NC];
    logic [63:0] m_cp  [2][NC];
    int          m_cs  [2][NC];
    int          m_cnt [2];

    always #5 clk = ~clk;

    cdb_arbiter #(.NUM_SRC(NS), .NUM_CDB(NC), .PKT_W(PW), .BYPASS(0), .CNT_W(CW)) dut0 (
        .i_clock(clk), .i_reset(rst), .i_nuke(nuke), .i_fu_valid(fu_valid),
        .i_fu_packet(fu_pkt), .o_src_ready(ready0), .o_cdb_valid(cv0),
        .o_cdb_packet(cp0), .o_cdb_src(cs0), .o_contention_cnt(cnt0));

    cdb_arbiter #(.NUM_SRC(NS), .NUM_CDB(NC), .PKT_W(PW), .BYPASS(1), .CNT_W(CW)) dut1 (
        .i_clock(clk), .i_reset(rst), .i_nuke(nuke), .i_fu_valid(fu_valid),
        .i_fu_packet(fu_pkt), .o_src_ready(ready1), .o_cdb_valid(cv1),
        .o_cdb_packet(cp1), .o_cdb_src(cs1), .o_contention_cnt(cnt1));

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic idle();
        rst      = 1'b0;
        nuke     = 1'b0;
        fu_valid = '0;
    endtask

    task automatic set_src(input int i, input logic [63:0] p);
        fu_valid[i]        = 1'b1;
        fu_pkt[i*PW +: PW] = p;
    endtask

    task automatic do_reset();
        rst = 1'b1; nuke = 1'b0; fu_valid = '0;
        tick();
        rst = 1'b0;
    endtask

    task automatic test_reset();
        rst = 1'b1; nuke = 1'b0; fu_valid = '1;
        #1;
        n_cmp++;
        if ({ready0, ready1} !== 16'h0) begin
            n_fail++; $display("FAIL reset_ready: got %h want 0000", {ready0, ready1});
        end
        tick();
        n_cmp++;
        if ({cv0, cp0, cs0, cnt0} !== '0) begin
            n_fail++; $display("FAIL reset_out0: got v=%b s=%h c=%0d want zeros", cv0, cs0, cnt0);
        end
        n_cmp++;
        if ({cv1, cp1, cs1, cnt1} !== '0) begin
            n_fail++; $display("FAIL reset_out1: got v=%b s=%h c=%0d want zeros", cv1, cs1, cnt1);
        end
        idle();
    endtask

    task automatic test_single();
        idle();
        set_src(3, 64'hA5);
        #1;
        n_cmp++;
        if (ready0[3] !== 1'b1) begin
            n_fail++; $display("FAIL single_ready: got %b want 1", ready0[3]);
        end
        tick();
        idle();
        tick();
        n_cmp++;
        if ({cv0, cp0[63:0], cs0[2:0]} !== {2'b01, 64'hA5, 3'd3}) begin
            n_fail++; $display("FAIL single_lane: got v=%b p=%h s=%0d want v=01 p=a5 s=3", cv0, cp0[63:0], cs0[2:0]);
        end
        // rr_ptr is now 4: with 2 and 4 competing, 4 must win lane 0.
        set_src(2, 64'h22);
        set_src(4, 64'h44);
        tick();
        idle();
        tick();
        n_cmp++;
        if ({cv0, cp0, cs0} !== {2'b11, 64'h22, 64'h44, 3'd2, 3'd4}) begin
            n_fail++; $display("FAIL single_rrptr: got v=%b s=%h want v=11 s=14", cv0, cs0);
        end
    endtask

    task automatic test_all_valid();
        logic [5:0] exp_s;
        logic [7:0] exp_r;
        int p;
        do_reset();
        for (int c = 0; c < 12; c++) begin
            fu_valid = '1;
            for (int i = 0; i < NS; i++) fu_pkt[i*PW +: PW] = {32'(c), 32'(i)};
            #1;
            p     = (c + 3) % 4;
            exp_r = (c == 0) ? 8'hFF : (8'h03 << (2 * p));
            n_cmp++;
            if (ready0 !== exp_r) begin
                n_fail++; $display("FAIL allv_ready c=%0d: got %h want %h", c, ready0, exp_r);
            end
            tick();
            if (c >= 1) begin
                exp_s = {3'(2 * p + 1), 3'(2 * p)};
                n_cmp++;
                if ({cv0, cs0} !== {2'b11, exp_s}) begin
                    n_fail++; $display("FAIL allv_grant c=%0d: got v=%b s=%h want v=11 s=%h", c, cv0, cs0, exp_s);
                end
            end
            n_cmp++;
            if (cnt0 !== CW'(c)) begin
                n_fail++; $display("FAIL allv_cnt c=%0d: got %0d want %0d", c, cnt0, c);
            end
        end
        idle();
    endtask

    task automatic test_wrap();
        do_reset();
        set_src(6, 64'h6);
        tick();
        idle();
        tick();
        set_src(1, 64'h1);
        set_src(7, 64'h7);
        tick();
        idle();
        tick();
        n_cmp++;
        if ({cv0, cs0, cp0} !== {2'b11, 3'd1, 3'd7, 64'h1, 64'h7}) begin
            n_fail++; $display("FAIL wrap_grant: got v=%b s=%h want v=11 s=0f", cv0, cs0);
        end
        set_src(1, 64'h10);
        set_src(3, 64'h30);
        tick();
        idle();
        tick();
        n_cmp++;
        if ({cv0, cs0} !== {2'b11, 3'd1, 3'd3}) begin
            n_fail++; $display("FAIL wrap_rrptr: got v=%b s=%h want v=11 s=0b", cv0, cs0);
        end
    endtask

    task automatic test_full_hold();
        do_reset();
        set_src(0, 64'h00);
        set_src(1, 64'h01);
        set_src(5, 64'h50);
        tick();
        idle();
        set_src(5, 64'h55B);
        #1;
        n_cmp++;
        if (ready0[5] !== 1'b0) begin
            n_fail++; $display("FAIL hold_blocked: got %b want 0", ready0[5]);
        end
        tick();
        #1;
        n_cmp++;
        if (ready0[5] !== 1'b1) begin
            n_fail++; $display("FAIL hold_drain_ready: got %b want 1", ready0[5]);
        end
        tick();
        n_cmp++;
        if ({cv0, cs0[2:0], cp0[63:0]} !== {2'b01, 3'd5, 64'h50}) begin
            n_fail++; $display("FAIL hold_retained: got v=%b s=%0d p=%h want v=01 s=5 p=50", cv0, cs0[2:0], cp0[63:0]);
        end
        idle();
        tick();
        n_cmp++;
        if ({cv0, cs0[2:0], cp0[63:0]} !== {2'b01, 3'd5, 64'h55B}) begin
            n_fail++; $display("FAIL hold_refill: got v=%b s=%0d p=%h want v=01 s=5 p=55b", cv0, cs0[2:0], cp0[63:0]);
        end
    endtask

    task automatic test_nuke();
        do_reset();
        set_src(4, 64'h4);
        tick();
        idle();
        tick();
        foreach (fu_valid[i]) if (i < 4 || i == 6) set_src(i, 64'(i + 256));
        tick();
        idle();
        nuke = 1'b1;
        set_src(7, 64'h77);
        #1;
        n_cmp++;
        if (ready0 !== 8'h00) begin
            n_fail++; $display("FAIL nuke_ready: got %h want 00", ready0);
        end
        tick();
        n_cmp++;
        if (cv0 !== 2'b00) begin
            n_fail++; $display("FAIL nuke_cdb: got %b want 00", cv0);
        end
        idle();
        #1;
        n_cmp++;
        if (ready0 !== 8'hFF) begin
            n_fail++; $display("FAIL nuke_hold_empty: got %h want ff", ready0);
        end
        tick();
        n_cmp++;
        if (cv0 !== 2'b00) begin
            n_fail++; $display("FAIL nuke_dropped: got %b want 00", cv0);
        end
        set_src(1, 64'h1);
        set_src(6, 64'h6);
        tick();
        idle();
        tick();
        n_cmp++;
        if ({cv0, cs0} !== {2'b11, 3'd6, 3'd1}) begin
            n_fail++; $display("FAIL nuke_rrptr: got v=%b s=%h want v=11 s=31", cv0, cs0);
        end
    endtask

    task automatic test_bypass();
        do_reset();
        set_src(2, 64'h11);
        #1;
        n_cmp++;
        if (ready1[2] !== 1'b1) begin
            n_fail++; $display("FAIL byp_ready: got %b want 1", ready1[2]);
        end
        tick();
        n_cmp++;
        if ({cv1, cs1[2:0], cp1[63:0]} !== {2'b01, 3'd2, 64'h11}) begin
            n_fail++; $display("FAIL byp_lane: got v=%b s=%0d p=%h want v=01 s=2 p=11", cv1, cs1[2:0], cp1[63:0]);
        end
        idle();
        tick();
        n_cmp++;
        if (cv1 !== 2'b00) begin
            n_fail++; $display("FAIL byp_hold_empty: got %b want 00", cv1);
        end
        fu_valid = '1;
        tick();
        tick();
        rst = 1'b1;
        #1;
        n_cmp++;
        if ({ready0, ready1} !== 16'h0) begin
            n_fail++; $display("FAIL midrst_ready: got %h want 0000", {ready0, ready1});
        end
        tick();
        n_cmp++;
        if ({cv0, cp0, cs0, cnt0, cv1, cp1, cs1, cnt1} !== '0) begin
            n_fail++; $display("FAIL midrst_out: got v0=%b c0=%0d v1=%b c1=%0d want zeros", cv0, cnt0, cv1, cnt1);
        end
        idle();
    endtask

    task automatic test_random();
        bit          cand, gr [2][NS];
        int          ng [2], nc [2], last [2], idx;
        int          lsrc [2][NC];
        logic [63:0] lpkt [2][NC];
        logic [NS-1:0] er [2];
        logic [NS-1:0] a_r;
        logic [NC-1:0] a_v;
        logic [NC*PW-1:0] a_p;
        logic [NC*3-1:0]  a_s;
        logic [CW-1:0]    a_c;
        bit          acc, byp;
        do_reset();
        for (int b = 0; b < 2; b++) begin
            m_rr[b] = 0; m_cnt[b] = 0;
            for (int i = 0; i < NS; i++) m_hv[b][i] = 0;
            for (int k = 0; k < NC; k++) m_cv[b][k] = 0;
        end
        for (int cyc = 0; cyc < 600; cyc++) begin
            rst      = ($urandom_range(0, 79) == 0);
            nuke     = ($urandom_range(0, 19) == 0);
            fu_valid = NS'($urandom);
            if ($urandom_range(0, 1) == 1) fu_valid = fu_valid & NS'($urandom);
            for (int i = 0; i < NS; i++) fu_pkt[i*PW +: PW] = {$urandom, $urandom};
            // Arbitration as the scan rules describe it: walk from rr, first NC candidates win.
            for (int b = 0; b < 2; b++) begin
                ng[b] = 0; nc[b] = 0; last[b] = 0;
                for (int i = 0; i < NS; i++) begin
                    gr[b][i] = 0;
                    nc[b] += (m_hv[b][i] || (b == 1 && fu_valid[i])) ? 1 : 0;
                end
                if (!rst && !nuke) begin
                    for (int j = 0; j < NS; j++) begin
                        idx  = (m_rr[b] + j) % NS;
                        cand = m_hv[b][idx] || (b == 1 && fu_valid[idx]);
                        if (cand && ng[b] < NC) begin
                            lsrc[b][ng[b]] = idx;
                            lpkt[b][ng[b]] = m_hv[b][idx] ? m_hp[b][idx] : fu_pkt[idx*PW +: PW];
                            gr[b][idx] = 1;
                            ng[b]++;
                            last[b] = idx;
                        end
                    end
                end
                for (int i = 0; i < NS; i++) er[b][i] = !rst && !nuke && (!m_hv[b][i] || gr[b][i]);
            end
            #1;
            for (int b = 0; b < 2; b++) begin
                a_r = (b == 0) ? ready0 : ready1;
                n_cmp++;
                if (a_r !== er[b]) begin
                    n_fail++; $display("FAIL rand_ready b=%0d cyc=%0d: got %h want %h", b, cyc, a_r, er[b]);
                end
            end
            tick();
            for (int b = 0; b < 2; b++) begin
                if (rst) begin
                    m_rr[b] = 0; m_cnt[b] = 0;
                    for (int i = 0; i < NS; i++) m_hv[b][i] = 0;
                    for (int k = 0; k < NC; k++) begin m_cv[b][k] = 0; m_cp[b][k] = 0; m_cs[b][k] = 0; end
                end else begin
                    if (nc[b] > NC && m_cnt[b] < 65535) m_cnt[b]++;
                    if (nuke) begin
                        m_rr[b] = 0;
                        for (int i = 0; i < NS; i++) m_hv[b][i] = 0;
                        for (int k = 0; k < NC; k++) m_cv[b][k] = 0;
                    end else begin
                        for (int k = 0; k < NC; k++) begin
                            m_cv[b][k] = (k < ng[b]);
                            if (k < ng[b]) begin m_cp[b][k] = lpkt[b][k]; m_cs[b][k] = lsrc[b][k]; end
                        end
                        for (int i = 0; i < NS; i++) begin
                            acc = fu_valid[i] && er[b][i];
                            byp = gr[b][i] && !m_hv[b][i];
                            if (acc && !byp) begin
                                m_hv[b][i] = 1; m_hp[b][i] = fu_pkt[i*PW +: PW];
                            end else if (gr[b][i]) begin
                                m_hv[b][i] = 0;
                            end
                        end
                        if (ng[b] > 0) m_rr[b] = (last[b] + 1) % NS;
                    end
                end
                a_v = (b == 0) ? cv0 : cv1;
                a_p = (b == 0) ? cp0 : cp1;
                a_s = (b == 0) ? cs0 : cs1;
                a_c = (b == 0) ? cnt0 : cnt1;
                n_cmp++;
                if (a_v !== {m_cv[b][1], m_cv[b][0]} || a_c !== CW'(m_cnt[b])) begin
                    n_fail++; $display("FAIL rand_valid_cnt b=%0d cyc=%0d: got v=%b c=%0d want v=%b%b c=%0d",
                                       b, cyc, a_v, a_c, m_cv[b][1], m_cv[b][0], m_cnt[b]);
                end
                for (int k = 0; k < NC; k++) begin
                    if (m_cv[b][k]) begin
                        n_cmp++;
                        if (a_p[k*PW +: PW] !== m_cp[b][k] || a_s[k*3 +: 3] !== 3'(m_cs[b][k])) begin
                            n_fail++; $display("FAIL rand_lane b=%0d k=%0d cyc=%0d: got s=%0d p=%h want s=%0d p=%h",
                                               b, k, cyc, a_s[k*3 +: 3], a_p[k*PW +: PW], m_cs[b][k], m_cp[b][k]);
                        end
                    end
                end
            end
        end
        idle();
    endtask

    initial begin
        rst      = 1'b1;
        nuke     = 1'b0;
        fu_valid = '0;
        fu_pkt   = '0;
        @(negedge clk);
        test_reset();
        test_single();
        test_all_valid();
        test_wrap();
        test_full_hold();
        test_nuke();
        test_bypass();
        test_random();
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: got timeout want completion");
        $fatal(1, "watchdog expired");
    end

endmodule : tb_cdb_arbiter
`default_nettype wire
